// File: rtl/quantizer_pkg.sv
// Shared types and width helpers for the noise-shaped quantizer and its DEM consumers.
package quantizer_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_NEAREST = 1'b1
    } round_mode_e;

    function automatic int step_f(input int in_w, input int out_w);
        return 1 << (in_w - out_w);
    endfunction

    function automatic int max_code_f(input int out_w);
        return (1 << out_w) - 1;
    endfunction

    function automatic int err_w_f(input int in_w, input int out_w);
        return in_w - out_w + 2;
    endfunction

endpackage

// File: rtl/bin2therm.sv
// Combinational binary-to-thermometer encoder: bit i is set when code exceeds i.
module bin2therm #(
    parameter int CODE_W  = 3,
    parameter int THERM_W = (1 << CODE_W) - 1
) (
    input  logic [CODE_W-1:0]  code_i,
    output logic [THERM_W-1:0] therm_o
);

    for (genvar g = 0; g < THERM_W; g++) begin : g_therm
        assign therm_o[g] = (code_i > CODE_W'(g));
    end

endmodule

// File: rtl/quantizer_ns.sv
// Uniform N-to-M bit quantizer with truncate/round modes, first-order error feedback,
// clamp detection with a sticky event counter, and a thermometer view of the code.
module quantizer_ns
    import quantizer_pkg::*;
#(
    parameter int INPUT_WIDTH   = 16,
    parameter int OUTPUT_WIDTH  = 3,
    parameter int SAT_CNT_WIDTH = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     valid_i,
    input  logic [INPUT_WIDTH-1:0]                   x_in_i,
    input  logic                                     round_en_i,
    input  logic                                     ns_en_i,
    input  logic                                     sat_clr_i,
    output logic                                     valid_o,
    output logic [OUTPUT_WIDTH-1:0]                  quantized_out_o,
    output logic [(1 << OUTPUT_WIDTH)-2:0]           therm_o,
    output logic signed [INPUT_WIDTH-OUTPUT_WIDTH+1:0] quant_error_o,
    output logic                                     sat_o,
    output logic [SAT_CNT_WIDTH-1:0]                 sat_cnt_o
);

    localparam int SHIFT    = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam int SUM_W    = INPUT_WIDTH + 2;
    localparam int ERR_W    = err_w_f(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int MAX_CODE = max_code_f(OUTPUT_WIDTH);
    localparam logic signed [SUM_W-1:0] HALF_STEP = SUM_W'(step_f(INPUT_WIDTH, OUTPUT_WIDTH) / 2);
    localparam logic signed [SUM_W-1:0] MAX_Q     = SUM_W'(MAX_CODE);

    function automatic logic signed [SUM_W-1:0] apply_round(
        input logic signed [SUM_W-1:0] s,
        input round_mode_e             mode
    );
        return (mode == RND_NEAREST) ? s + HALF_STEP : s;
    endfunction

    function automatic logic is_sat(input logic signed [SUM_W-1:0] q);
        return q[SUM_W-1] || (q > MAX_Q);
    endfunction

    function automatic logic [OUTPUT_WIDTH-1:0] clamp_code(input logic signed [SUM_W-1:0] q);
        if (q[SUM_W-1])
            return '0;
        else if (q > MAX_Q)
            return '1;
        else
            return q[OUTPUT_WIDTH-1:0];
    endfunction

    logic signed [ERR_W-1:0]        err_q;
    logic signed [SUM_W-1:0]        err_ext;
    logic signed [SUM_W-1:0]        sum_p0;
    logic signed [SUM_W-1:0]        t_p0;
    logic signed [SUM_W-1:0]        q_p0;
    logic signed [SUM_W-1:0]        code_scaled_p0;
    logic [OUTPUT_WIDTH-1:0]        code_p0;
    logic signed [ERR_W-1:0]        err_p0;
    logic                           sat_p0;

    logic                           vld_p1;
    logic [OUTPUT_WIDTH-1:0]        code_p1;
    logic signed [ERR_W-1:0]        err_p1;
    logic                           sat_p1;
    logic [SAT_CNT_WIDTH-1:0]       sat_cnt_p1;

    // p0: combinational datapath on the incoming sample
    assign err_ext        = {{(SUM_W - ERR_W){err_q[ERR_W-1]}}, err_q};
    assign sum_p0         = $signed({2'b00, x_in_i}) + (ns_en_i ? err_ext : '0);
    assign t_p0           = apply_round(sum_p0, round_mode_e'(round_en_i));
    assign q_p0           = t_p0 >>> SHIFT;
    assign sat_p0         = is_sat(q_p0);
    assign code_p0        = clamp_code(q_p0);
    assign code_scaled_p0 = $signed(SUM_W'({code_p0, {SHIFT{1'b0}}}));
    // The true error always fits ERR_W, so dropping the top bits of the difference is exact.
    assign err_p0         = ERR_W'(sum_p0 - code_scaled_p0);

    // p1: output registers, feedback state and clamp counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1     <= 1'b0;
            code_p1    <= '0;
            err_p1     <= '0;
            sat_p1     <= 1'b0;
            err_q      <= '0;
            sat_cnt_p1 <= '0;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i) begin
                code_p1 <= code_p0;
                err_p1  <= err_p0;
                sat_p1  <= sat_p0;
                // Anti-windup: a clamped sample must not feed its large error forward.
                err_q   <= sat_p0 ? '0 : err_p0;
            end
            if (sat_clr_i)
                sat_cnt_p1 <= '0;
            else if (valid_i && sat_p0 && !(&sat_cnt_p1))
                sat_cnt_p1 <= sat_cnt_p1 + 1'b1;
        end
    end

    assign valid_o         = vld_p1;
    assign quantized_out_o = code_p1;
    assign quant_error_o   = err_p1;
    assign sat_o           = sat_p1;
    assign sat_cnt_o       = sat_cnt_p1;

    bin2therm #(
        .CODE_W (OUTPUT_WIDTH)
    ) u_bin2therm (
        .code_i  (code_p1),
        .therm_o (therm_o)
    );

endmodule

// File: tb/tb_quantizer_ns.sv
// Bench for quantizer_ns: directed vector table, corner sequences and randomized model comparison.
module tb_quantizer_ns;

    localparam int STEP   = 8192;
    localparam int MAXC   = 7;
    localparam int CNTMAX = 255;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic [15:0]        x_in;
    logic               round_en;
    logic               ns_en;
    logic               sat_clr;
    logic               valid_o;
    logic [2:0]         code;
    logic [6:0]         therm;
    logic signed [14:0] qerr;
    logic               sat;
    logic [7:0]         sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int m_valid = 0, m_code = 0, m_err = 0, m_sat = 0, m_cnt = 0, m_errq = 0;

    typedef struct {
        bit v; int x; bit rnd; bit ns; bit clr;
        int code; int err; int therm; int sat; int cnt;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    quantizer_ns #(
        .INPUT_WIDTH   (16),
        .OUTPUT_WIDTH  (3),
        .SAT_CNT_WIDTH (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .valid_i         (valid_i),
        .x_in_i          (x_in),
        .round_en_i      (round_en),
        .ns_en_i         (ns_en),
        .sat_clr_i       (sat_clr),
        .valid_o         (valid_o),
        .quantized_out_o (code),
        .therm_o         (therm),
        .quant_error_o   (qerr),
        .sat_o           (sat),
        .sat_cnt_o       (sat_cnt)
    );

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input int x, input bit rnd, input bit ns, input bit clr);
        int sum, q, c;
        bit s;
        s = 1'b0;
        if (r) begin
            m_valid = 0; m_code = 0; m_err = 0; m_sat = 0; m_cnt = 0; m_errq = 0;
            return;
        end
        m_valid = v;
        if (v) begin
            sum = x + (ns ? m_errq : 0);
            q = floor_div(sum + (rnd ? STEP / 2 : 0), STEP);
            c = (q > MAXC) ? MAXC : ((q < 0) ? 0 : q);
            s = (q != c);
            m_code = c;
            m_sat = s;
            m_err = sum - c * STEP;
            m_errq = s ? 0 : m_err;
        end
        if (clr) m_cnt = 0;
        else if (v && s && m_cnt < CNTMAX) m_cnt++;
    endtask

    task automatic check_model();
        check("valid_o", valid_o, m_valid);
        check("code", code, m_code);
        check("therm", therm, (1 << m_code) - 1);
        check("quant_error", qerr, m_err);
        check("sat_o", sat, m_sat);
        check("sat_cnt", sat_cnt, m_cnt);
    endtask

    task automatic step(input bit r, input bit v, input int x, input bit rnd, input bit ns, input bit clr);
        rst = r; valid_i = v; x_in = 16'(x); round_en = rnd; ns_en = ns; sat_clr = clr;
        @(posedge clk);
        model_edge(r, v, x & 16'hFFFF, rnd, ns, clr);
        #1;
        check_model();
    endtask

    initial begin
        // {v, x, rnd, ns, clr, code, err, therm, sat, cnt}
        tbl.push_back('{1, 0,     0, 0, 0, 0, 0,     7'h00, 0, 0});
        tbl.push_back('{1, 8191,  0, 0, 0, 0, 8191,  7'h00, 0, 0});
        tbl.push_back('{1, 16384, 0, 0, 0, 2, 0,     7'h03, 0, 0});
        tbl.push_back('{1, 65535, 0, 0, 0, 7, 8191,  7'h7F, 0, 0});
        tbl.push_back('{1, 12288, 1, 0, 0, 2, -4096, 7'h03, 0, 0});
        tbl.push_back('{1, 4095,  1, 0, 0, 0, 4095,  7'h00, 0, 0});
        tbl.push_back('{1, 61440, 1, 0, 0, 7, 4096,  7'h7F, 1, 1});
        tbl.push_back('{1, 4096,  0, 1, 0, 0, 4096,  7'h00, 0, 1});
        tbl.push_back('{1, 4096,  0, 1, 0, 1, 0,     7'h01, 0, 1});
        tbl.push_back('{1, 4096,  0, 1, 0, 0, 4096,  7'h00, 0, 1});
        tbl.push_back('{1, 4096,  0, 1, 0, 1, 0,     7'h01, 0, 1});
        tbl.push_back('{1, 12288, 1, 1, 0, 2, -4096, 7'h03, 0, 1});
        tbl.push_back('{1, 12288, 1, 1, 0, 1, 0,     7'h01, 0, 1});
        tbl.push_back('{1, 12288, 1, 1, 0, 2, -4096, 7'h03, 0, 1});
        tbl.push_back('{1, 0,     0, 0, 0, 0, 0,     7'h00, 0, 1});
        tbl.push_back('{1, 65535, 0, 1, 0, 7, 8191,  7'h7F, 0, 1});
        tbl.push_back('{1, 65535, 0, 1, 0, 7, 16382, 7'h7F, 1, 2});
        tbl.push_back('{1, 0,     0, 1, 0, 0, 0,     7'h00, 0, 2});
        tbl.push_back('{1, 61440, 1, 0, 1, 7, 4096,  7'h7F, 1, 0});

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 12345, 1, 1, 0);
        check("reset_valid", valid_o, 0);
        check("reset_code", code, 0);
        check("reset_therm", therm, 0);
        check("reset_err", qerr, 0);
        check("reset_sat", sat, 0);
        check("reset_cnt", sat_cnt, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(0, tbl[i].v, tbl[i].x, tbl[i].rnd, tbl[i].ns, tbl[i].clr);
            check($sformatf("row%0d_valid", i), valid_o, 1);
            check($sformatf("row%0d_code", i), code, tbl[i].code);
            check($sformatf("row%0d_err", i), qerr, tbl[i].err);
            check($sformatf("row%0d_therm", i), therm, tbl[i].therm);
            check($sformatf("row%0d_sat", i), sat, tbl[i].sat);
            check($sformatf("row%0d_cnt", i), sat_cnt, tbl[i].cnt);
        end

        // Gap: idle cycles must hold outputs and the stored error.
        step(0, 1, 4096, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 12345, 1, 1, 0);
            check("gap_valid", valid_o, 0);
            check("gap_code_hold", code, 0);
            check("gap_err_hold", qerr, 4096);
        end
        step(0, 1, 4096, 0, 1, 0);
        check("gap_errq_held_code", code, 1);
        check("gap_errq_held_err", qerr, 0);

        // Clear acts without a valid sample.
        step(0, 1, 61440, 1, 0, 0);
        check("clr_pre_cnt", sat_cnt, 1);
        step(0, 0, 0, 0, 0, 1);
        check("clr_novalid_cnt", sat_cnt, 0);

        // Counter sticks at all-ones.
        for (int i = 0; i < 300; i++) step(0, 1, 61440, 1, 0, 0);
        check("cnt_sticky", sat_cnt, 255);

        // Mid-stream reset discards state and the in-flight sample.
        step(0, 1, 4096, 0, 0, 0);
        step(1, 1, 4096, 0, 1, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_code", code, 0);
        check("midrst_err", qerr, 0);
        check("midrst_cnt", sat_cnt, 0);
        step(0, 1, 4096, 0, 1, 0);
        check("postrst_code", code, 0);
        check("postrst_err", qerr, 4096);

        for (int i = 0; i < 2000; i++) begin
            int sel, x;
            sel = $urandom_range(0, 3);
            case (sel)
                0: x = $urandom_range(0, 65535);
                1: x = $urandom_range(60000, 65535);
                2: x = $urandom_range(0, 3000);
                default: x = $urandom_range(0, 7) * STEP + $urandom_range(4090, 4100);
            endcase
            if (x > 65535) x = 65535;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), x,
                 $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
